// File: rtl/sr_pulse_gen.sv
// Debounced push-button driver producing mutually exclusive set/reset pulses for an SR flip-flop.
// Optional auto-repeat of held buttons is enabled by defining SR_AUTO_REPEAT_EN.
module sr_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_LEN       = 1,
  parameter int BTN_ACTIVE_LOW  = 1,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_set,
  input  logic btn_reset,
  output logic s,
  output logic r,
  output logic busy,
  output logic set_lvl,
  output logic reset_lvl
);

  localparam int   DW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int   PW       = $clog2(PULSE_LEN + 1);
  localparam logic IDLE_LVL = (BTN_ACTIVE_LOW != 0);

  typedef enum logic { IDLE, PULSE } state_t;
  typedef enum logic { SEL_SET, SEL_RST } sel_t;

  // Index 0 is the set button, index 1 the reset button throughout.
  logic [1:0]    sync_set, sync_rst;
  logic [1:0]    pressed;
  logic [1:0]    lvl, lvl_d;
  logic [DW-1:0] db_cnt [2];
  logic [1:0]    press;
  logic [1:0]    ev;

  state_t        state, state_n;
  sel_t          sel, sel_n;
  logic [PW-1:0] cnt, cnt_n;
  logic          s_n, r_n;

  // Stage 0: two-flop synchronisers, reset to the released level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_set <= {2{IDLE_LVL}};
      sync_rst <= {2{IDLE_LVL}};
    end else begin
      sync_set <= {sync_set[0], btn_set};
      sync_rst <= {sync_rst[0], btn_reset};
    end
  end

  assign pressed = {sync_rst[1] ^ IDLE_LVL, sync_set[1] ^ IDLE_LVL};

  // Stage 1: debounce counters and debounced levels
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl   <= '0;
      lvl_d <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      lvl_d <= lvl;
      for (int i = 0; i < 2; i++) begin
        if (pressed[i] == lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          lvl[i]    <= ~lvl[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign press = lvl & ~lvl_d;

`ifdef SR_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic [RW-1:0] rep_tmr [2];
  logic [1:0]    rep_hit;
  logic          drop_set;

  always_comb begin
    rep_hit = '0;
    for (int i = 0; i < 2; i++)
      rep_hit[i] = lvl[i] && (rep_tmr[i] == RW'(REPEAT_CYCLES));
  end

  assign ev       = press | rep_hit;
  // A set event lost to a simultaneous reset event restarts the set timer.
  assign drop_set = (state == IDLE) && ev[0] && ev[1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst || !lvl[i])
        rep_tmr[i] <= '0;
      else if (i == 0 && drop_set)
        rep_tmr[i] <= '0;
      else if (ev[i])
        rep_tmr[i] <= RW'(1);
      else
        rep_tmr[i] <= rep_tmr[i] + RW'(1);
    end
  end
`else
  assign ev = press;
`endif

  // Stage 2: pulse FSM; reset events take priority and preempt a set pulse
  always_comb begin
    state_n = state;
    sel_n   = sel;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (ev[1]) begin
          state_n = PULSE;
          sel_n   = SEL_RST;
          cnt_n   = PW'(1);
        end else if (ev[0]) begin
          state_n = PULSE;
          sel_n   = SEL_SET;
          cnt_n   = PW'(1);
        end
      end
      PULSE: begin
        if (ev[1] && sel == SEL_SET) begin
          sel_n = SEL_RST;
          cnt_n = PW'(1);
        end else if (cnt == PW'(PULSE_LEN)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + PW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    s_n = (state_n == PULSE) && (sel_n == SEL_SET);
    r_n = (state_n == PULSE) && (sel_n == SEL_RST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= SEL_SET;
      cnt   <= '0;
      s     <= 1'b0;
      r     <= 1'b0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      cnt   <= cnt_n;
      s     <= s_n;
      r     <= r_n;
    end
  end

  assign busy      = (state == PULSE);
  assign set_lvl   = lvl[0];
  assign reset_lvl = lvl[1];

endmodule
